muldiv_seq: RTL
===============

# muldiv_seq

Parametrised sequential multiply/divide unit. It replaces the fixed 1-bit-per-cycle unsigned shift-add multiplier embedded in the execute stage. It adds a configurable radix, signed/unsigned/mixed multiply, signed and unsigned divide, early-out on special cases, and abort. Execute issues one operation with `start`, stalls while `busy`, and takes the result on `done`. The high half stays architecturally readable and writable as the multiplier register (r7).

## Interface
- RV, 32: operand width; 16 or 32.
- STEP, 1: result bits retired per iteration; 1, 2 or 4; must divide RV.
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  issue an operation; sampled only when `busy`=0.
- op  in  3  operation code (see Operation).
- a  in  RV  multiplicand / dividend.
- b  in  RV  multiplier / divisor.
- abort  in  1  kill an in-flight operation (trap or interrupt).
- hi_wr  in  1  write `hi_wdata` into the high result register.
- hi_wdata  in  RV  data for `hi_wr`.
- busy  out  1  operation in flight; reset 0.
- done  out  1  one-cycle pulse when the result is valid; reset 0.
- result_lo  out  RV  product[RV-1:0] or quotient; reset 0.
- result_hi  out  RV  product[2RV-1:RV] or remainder; reset 0.
- dbz  out  1  one-cycle pulse with `done` on divide by zero; reset 0.

## Operation
- op encoding:
  - 000 MULU: unsigned × unsigned.
  - 001 MULS: signed × signed.
  - 010 MULSU: signed a × unsigned b.
  - 100 DIVU: unsigned divide.
  - 101 DIV: signed divide.
  - Other codes are reserved. They complete as early-out with both results 0.
- States:
  - IDLE → RUN on start. → EARLY on start with a special case.
  - RUN → FIX after the last iteration.
  - FIX → IDLE, with `done` asserted.
  - EARLY → IDLE, with `done` asserted.
- Multiply:
  - Operands are converted to magnitudes at start.
  - Each RUN cycle adds b × (next STEP bits of a, MSB first) to the accumulator, which is shifted left by STEP.
  - FIX negates the 2RV-bit product if the sign of a XOR the sign of b is 1 (signed modes only).
- Divide:
  - Restoring divide on magnitudes, STEP quotient bits per cycle.
  - FIX applies signs: quotient takes sign(a)^sign(b); remainder takes sign(a).
- Special cases (EARLY, no iterations):
  - b==0, divide: quotient = all-ones, remainder = a, `dbz`=1.
  - DIV with a = -2^(RV-1) and b = -1: quotient = a, remainder = 0.
  - Multiply with a==0 or b==0: product 0.
- `hi_wr`:
  - In IDLE: result_hi ← hi_wdata on the next edge; result_lo is unchanged.
  - While busy: ignored.
  - Same cycle as `start`: `start` wins and `hi_wr` is dropped.
- `abort`:
  - Any state → IDLE next cycle.
  - No `done`; the result registers hold their pre-start values.
  - `abort` together with `start` in IDLE: the operation is not accepted.
- Reset (reset_n=0 at any edge):
  - All outputs go to 0 and the state goes to IDLE, including mid-operation.
- Results hold until the next accepted start or `hi_wr`.

## Timing
- `start` is sampled at edge 0. `busy` is 1 from cycle 1.
- Normal latency: N = RV/STEP RUN cycles, then 1 FIX cycle. `done`=1 in cycle N+1, with `busy` still 1 in that cycle; `busy`=0 in cycle N+2.
  - RV=32: STEP=1 gives `done` at cycle 33; STEP=4 gives `done` at cycle 9.
- EARLY latency: `done` at cycle 1, `busy`=1 in cycle 1 only.
- A new `start` is accepted in the first cycle with `busy`=0, so back-to-back operations are separated by one idle cycle.
- `result_lo`/`result_hi` are valid in the `done` cycle. Execute writes result_lo into rd in that cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MULDIV_DIV_EN defined:
  - Divider datapath and divide opcodes are present.
- MULDIV_DIV_EN undefined:
  - Codes 100/101 are treated as reserved: EARLY, results 0, `dbz`=0.
  - No divide logic is synthesised.

## Structure
- Package `muldiv_pkg` holds:
  - the op encoding constants (MD_MULU, MD_MULS, MD_MULSU, MD_DIVU, MD_DIV);
  - the state enum (IDLE, RUN, EARLY, FIX);
  - the helper function `md_is_signed_a(op)`.
- Sub-module `muldiv_step` is combinational. It is parametrised by RV and STEP and performs one iteration:
  - multiply: accumulate-and-shift;
  - divide: trial-subtract-and-shift.
- The top level holds the state machine, counter (log2(RV/STEP) bits), operand and sign registers, and the FIX negation.

## Test plan
- MULS, RV=32, STEP=1, a=-3, b=7 → `done` at cycle 33; result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF.
- MULU, STEP=4, a=0xFFFFFFFF, b=0xFFFFFFFF → `done` at cycle 9; result_hi=0xFFFFFFFE, result_lo=0x00000001.
- DIV, a=-7, b=2 → result_lo=-3 (0xFFFFFFFD), result_hi=-1. DIVU, a=7, b=0 → `done` at cycle 1, result_lo=0xFFFFFFFF, result_hi=7, `dbz`=1.
- DIV, a=0x80000000, b=0xFFFFFFFF → EARLY; result_lo=0x80000000, result_hi=0.
- Start MULU, pulse `abort` at cycle 10 → `busy`=0 at cycle 11; no `done`; results equal their pre-start values.
- In IDLE, `hi_wr` with hi_wdata=0x1234 → result_hi=0x1234 next cycle. Assert reset_n=0 mid-RUN → all outputs 0 the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state type and decode helpers shared by the muldiv_seq block.
package muldiv_pkg;

  localparam logic [2:0] MD_MULU  = 3'b000;
  localparam logic [2:0] MD_MULS  = 3'b001;
  localparam logic [2:0] MD_MULSU = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_DIV   = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EARLY,
    FIX
  } md_state_e;

  // Operand a is treated as two's complement.
  function automatic logic md_is_signed_a(input logic [2:0] op);
    return (op == MD_MULS) || (op == MD_MULSU) || (op == MD_DIV);
  endfunction

  // Operand b is treated as two's complement.
  function automatic logic md_is_signed_b(input logic [2:0] op);
    return (op == MD_MULS) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULU) || (op == MD_MULS) || (op == MD_MULSU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: issue/result bundle between the execute stage (master) and muldiv_seq (slave).
interface muldiv_seq_if #(
  parameter int unsigned RV = 32
);
  logic          start;
  logic [2:0]    op;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic          abort;
  logic          hi_wr;
  logic [RV-1:0] hi_wdata;
  logic          busy;
  logic          done;
  logic [RV-1:0] result_lo;
  logic [RV-1:0] result_hi;
  logic          dbz;

  modport master (
    output start, op, a, b, abort, hi_wr, hi_wdata,
    input  busy, done, result_lo, result_hi, dbz
  );

  modport slave (
    input  start, op, a, b, abort, hi_wr, hi_wdata,
    output busy, done, result_lo, result_hi, dbz
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequential multiply/divide datapath.
// Multiply: acc = (acc << STEP) + b * (top STEP bits of a), a shifted left by STEP.
// Divide (only with MULDIV_DIV_EN): STEP restoring trial-subtract steps on {rem, quo} held in acc.
module muldiv_step #(
  parameter int unsigned RV   = 32,
  parameter int unsigned STEP = 1
) (
  input  logic            i_div,
  input  logic [2*RV-1:0] i_acc,
  input  logic [RV-1:0]   i_ma,
  input  logic [RV-1:0]   i_mb,
  output logic [2*RV-1:0] o_acc,
  output logic [RV-1:0]   o_ma
);

  localparam int unsigned AW = 2 * RV;

  logic [STEP-1:0] w_digit;
  logic [AW-1:0]   w_pp;
  logic [AW-1:0]   w_mul_acc;

  assign w_digit = i_ma[RV-1 -: STEP];

  // Partial product b * digit built from shifted copies of b.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < int'(STEP); j++) begin
      if (w_digit[j]) begin
        w_pp = w_pp + (AW'(i_mb) << j);
      end
    end
  end

  assign w_mul_acc = (i_acc << STEP) + w_pp;

`ifdef MULDIV_DIV_EN
  logic [RV:0]   w_rem;
  logic [RV-1:0] w_quo;

  // Restoring division: acc high half is the partial remainder, low half the dividend
  // being shifted out MSB first while quotient bits shift in at the bottom.
  always_comb begin
    w_rem = {1'b0, i_acc[AW-1:RV]};
    w_quo = i_acc[RV-1:0];
    for (int k = 0; k < int'(STEP); k++) begin
      w_rem = {w_rem[RV-1:0], w_quo[RV-1]};
      w_quo = {w_quo[RV-2:0], 1'b0};
      if (w_rem >= {1'b0, i_mb}) begin
        w_rem    = w_rem - {1'b0, i_mb};
        w_quo[0] = 1'b1;
      end
    end
  end

  // Select the active datapath.
  always_comb begin
    o_acc = i_div ? {w_rem[RV-1:0], w_quo} : w_mul_acc;
    o_ma  = i_ma << STEP;
  end
`else
  logic w_unused_div;
  assign w_unused_div = i_div;

  // Multiply is the only datapath in this build.
  always_comb begin
    o_acc = w_mul_acc;
    o_ma  = i_ma << STEP;
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential multiply/divide unit, STEP result bits per RUN cycle.
// Optional feature macro: MULDIV_DIV_EN (divider datapath and divide opcodes).
// Without it, divide opcodes complete as reserved (EARLY, zero results, no dbz).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned RV   = 32,
  parameter int unsigned STEP = 1
) (
  input logic         i_clk,
  input logic         i_reset_n,
  muldiv_seq_if.slave bus
);

  localparam int unsigned N    = RV / STEP;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  md_state_e       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2*RV-1:0] r_acc;
  logic [RV-1:0]   r_ma;
  logic [RV-1:0]   r_mb;
  logic            r_neg_lo;  // negate product (mul) or quotient (div)
  logic            r_busy;
  logic            r_done;
  logic            r_dbz;
  logic [RV-1:0]   r_lo;
  logic [RV-1:0]   r_hi;
`ifdef MULDIV_DIV_EN
  logic            r_is_div;
  logic            r_neg_hi;  // negate remainder
`endif

  logic            w_sa;
  logic            w_sb;
  logic [RV-1:0]   w_abs_a;
  logic [RV-1:0]   w_abs_b;
  logic            w_is_mul;
  logic            w_is_div;
  logic            w_early;
  logic            w_early_dbz;
  logic [RV-1:0]   w_early_lo;
  logic [RV-1:0]   w_early_hi;
  logic            w_step_div;
  logic [2*RV-1:0] w_step_acc;
  logic [RV-1:0]   w_step_ma;
  logic [2*RV-1:0] w_prod;
  logic [RV-1:0]   w_fix_lo;
  logic [RV-1:0]   w_fix_hi;

  // Issue-time decode: operand signs, magnitudes and special-case results.
  always_comb begin
    w_sa     = md_is_signed_a(bus.op) & bus.a[RV-1];
    w_sb     = md_is_signed_b(bus.op) & bus.b[RV-1];
    w_abs_a  = w_sa ? -bus.a : bus.a;
    w_abs_b  = w_sb ? -bus.b : bus.b;
    w_is_mul = md_is_mul(bus.op);
`ifdef MULDIV_DIV_EN
    w_is_div = md_is_div(bus.op);
`else
    w_is_div = 1'b0;
`endif
    w_early     = 1'b1;
    w_early_dbz = 1'b0;
    w_early_lo  = '0;
    w_early_hi  = '0;
    if (w_is_mul) begin
      w_early = (bus.a == '0) || (bus.b == '0);
    end else if (w_is_div) begin
      if (bus.b == '0) begin
        w_early_lo  = '1;
        w_early_hi  = bus.a;
        w_early_dbz = 1'b1;
      end else if ((bus.op == MD_DIV) && (bus.a == {1'b1, {(RV-1){1'b0}}}) &&
                   (bus.b == '1)) begin
        w_early_lo = bus.a;
      end else begin
        w_early = 1'b0;
      end
    end
  end

`ifdef MULDIV_DIV_EN
  assign w_step_div = r_is_div;
`else
  assign w_step_div = 1'b0;
`endif

  muldiv_step #(
    .RV  (RV),
    .STEP(STEP)
  ) u_step (
    .i_div(w_step_div),
    .i_acc(r_acc),
    .i_ma (r_ma),
    .i_mb (r_mb),
    .o_acc(w_step_acc),
    .o_ma (w_step_ma)
  );

  // Sign fix-up applied to the final iteration's output, so results and done register together.
  always_comb begin
    w_prod   = r_neg_lo ? -w_step_acc : w_step_acc;
    w_fix_lo = w_prod[RV-1:0];
    w_fix_hi = w_prod[2*RV-1:RV];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      w_fix_lo = r_neg_lo ? -w_step_acc[RV-1:0] : w_step_acc[RV-1:0];
      w_fix_hi = r_neg_hi ? -w_step_acc[2*RV-1:RV] : w_step_acc[2*RV-1:RV];
    end
`endif
  end

  // Control FSM with registered outputs; the result registers only change on completion or hi_wr.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_neg_lo <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_mb     <= w_abs_b;
              r_neg_lo <= w_sa ^ w_sb;
`ifdef MULDIV_DIV_EN
              r_is_div <= w_is_div;
              r_neg_hi <= w_sa;
`endif
              if (w_early) begin
                r_state <= EARLY;
                r_done  <= 1'b1;
                r_dbz   <= w_early_dbz;
                r_lo    <= w_early_lo;
                r_hi    <= w_early_hi;
              end else begin
                r_state <= RUN;
                r_ma    <= w_abs_a;
                r_acc   <= w_is_div ? {{RV{1'b0}}, w_abs_a} : '0;
              end
            end else if (bus.hi_wr) begin
              r_hi <= bus.hi_wdata;
            end
          end
          RUN: begin
            r_acc <= w_step_acc;
            r_ma  <= w_step_ma;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state <= FIX;
              r_done  <= 1'b1;
              r_lo    <= w_fix_lo;
              r_hi    <= w_fix_hi;
            end
          end
          FIX, EARLY: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbz       = r_dbz;
  assign bus.result_lo = r_lo;
  assign bus.result_hi = r_hi;

endmodule
